// File: rtl/simple_isa_pkg.sv
// simple_isa_pkg: opcode, phase and fault encodings shared by the sequencer and decode/execute.
package simple_isa_pkg;

    typedef enum logic [3:0] {
        MOV_LD  = 4'd0,
        MOV_ST  = 4'd1,
        MOV_IND = 4'd2,
        MOV_IMM = 4'd3,
        ADD     = 4'd4,
        SUB     = 4'd5,
        JZ      = 4'd8,
        JNZ     = 4'd9
    } opcode_t;

    localparam logic [1:0] IF = 2'd0;
    localparam logic [1:0] ID = 2'd1;
    localparam logic [1:0] EX = 2'd2;
    localparam logic [1:0] WB = 2'd3;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_TIMEOUT = 2'd2
    } fault_code_t;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        return op inside {MOV_LD, MOV_ST, MOV_IND, MOV_IMM, ADD, SUB, JZ, JNZ};
    endfunction

    function automatic logic is_single_phase(input logic [3:0] op);
        return op == MOV_IMM;
    endfunction

endpackage

// File: rtl/simple_seq_ctrl.sv
// simple_seq_ctrl: PC owner and IF/ID/EX/WB phase sequencer with sticky fault handling.
module simple_seq_ctrl
    import simple_isa_pkg::*;
#(
    parameter logic [7:0]  RESET_PC      = 8'h00,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        clr_fault,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic [7:0]  pc_incr,
    output logic [15:0] INSTR,
    output logic [1:0]  phase,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_ID, S_EX, S_WB, S_FAULT
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(FETCH_TIMEOUT - 1);

    state_t      state, nxt;
    fault_code_t fc;
    logic [7:0]  wait_cnt;
    logic        retire, rlegal, timed_out;

    assign rlegal    = is_legal_opcode(imem_rdata[15:12]);
    assign timed_out = wait_cnt == LAST_WAIT;

    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            S_IDLE:       nxt = run ? S_FETCH_REQ : S_IDLE;
            S_FETCH_REQ:  nxt = S_FETCH_WAIT;
            // valid data on the last wait cycle beats the timeout
            S_FETCH_WAIT: nxt = imem_rvalid ? (rlegal ? S_ID : S_FAULT)
                                            : (timed_out ? S_FAULT : S_FETCH_WAIT);
            S_ID: begin
                retire = is_single_phase(INSTR[15:12]);
                nxt    = S_EX;
            end
            S_EX:         nxt = S_WB;
            S_WB:         retire = 1'b1;
            S_FAULT:      nxt = clr_fault ? S_IDLE : S_FAULT;
            default:      nxt = S_IDLE;
        endcase
        if (retire) nxt = run ? S_FETCH_REQ : S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            INSTR      <= '0;
            fc         <= FC_NONE;
            retire_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH_REQ) wait_cnt <= '0;
            if (state == S_FETCH_WAIT) begin
                if (imem_rvalid) begin
                    INSTR <= imem_rdata;
                    if (!rlegal) fc <= FC_ILLEGAL;
                end else if (timed_out) begin
                    fc <= FC_TIMEOUT;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
            if (retire) begin
                pc         <= pc + pc_incr;
                retire_cnt <= retire_cnt + 16'd1;
            end
            if (state == S_FAULT && clr_fault) begin
                pc <= RESET_PC;
                fc <= FC_NONE;
            end
        end
    end

    assign imem_req   = state == S_FETCH_REQ;
    assign imem_addr  = pc;
    assign busy       = !(state == S_IDLE || state == S_FAULT);
    assign fault      = state == S_FAULT;
    assign fault_code = fc;
    assign phase      = state == S_ID ? ID : state == S_EX ? EX : state == S_WB ? WB : IF;

endmodule

// File: tb/tb_simple_seq_ctrl.sv
// tb_simple_seq_ctrl: directed plan scenarios plus randomized run against a transaction-level model.
module tb_simple_seq_ctrl;

    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         TO       = 15;

    logic        clk = 1'b0, resetn = 1'b0, run = 1'b0, clr_fault = 1'b0;
    logic        imem_req, imem_rvalid = 1'b0, busy, fault;
    logic [7:0]  imem_addr, pc_incr = 8'h00, pc;
    logic [15:0] imem_rdata = 16'h0000, INSTR, retire_cnt;
    logic [1:0]  phase, fault_code;

    simple_seq_ctrl #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .run(run), .clr_fault(clr_fault),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid), .pc_incr(pc_incr), .INSTR(INSTR), .phase(phase),
        .pc(pc), .busy(busy), .fault(fault), .fault_code(fault_code), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Behavioural model: an instruction is a fetch wait followed by a list of phases to walk.
    typedef enum {M_IDLE, M_REQ, M_WAIT, M_RUN, M_FAULT} mmode_t;
    logic [15:0] legal_mask = 16'h033F;
    mmode_t      mm = M_IDLE;
    int          waited = 0;
    int          phq[$];
    logic [7:0]  m_pc = RESET_PC;
    logic [15:0] m_rc = 0, m_instr = 0;
    logic [1:0]  m_fc = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mm = M_IDLE; m_pc = RESET_PC; m_rc = 0; m_instr = 0; m_fc = 0; phq.delete();
        end else begin
            case (mm)
                M_IDLE: if (run) mm = M_REQ;
                M_REQ: begin mm = M_WAIT; waited = 0; end
                M_WAIT: begin
                    waited++;
                    if (imem_rvalid) begin
                        m_instr = imem_rdata;
                        if (legal_mask[imem_rdata[15:12]]) begin
                            if (imem_rdata[15:12] == 4'd3) phq = {1};
                            else phq = {1, 2, 3};
                            mm = M_RUN;
                        end else begin
                            m_fc = 1; mm = M_FAULT;
                        end
                    end else if (waited == TO) begin
                        m_fc = 2; mm = M_FAULT;
                    end
                end
                M_RUN: begin
                    if (phq.size() == 1) begin
                        m_pc = m_pc + pc_incr; m_rc = m_rc + 1; phq.delete();
                        mm = run ? M_REQ : M_IDLE;
                    end else void'(phq.pop_front());
                end
                M_FAULT: if (clr_fault) begin mm = M_IDLE; m_pc = RESET_PC; m_fc = 0; end
                default: mm = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("phase", phase, (mm == M_RUN && phq.size() > 0) ? phq[0] : 0);
        chk("imem_req", imem_req, mm == M_REQ);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("busy", busy, mm inside {M_REQ, M_WAIT, M_RUN});
        chk("fault", fault, mm == M_FAULT);
        chk("fault_code", fault_code, m_fc);
        chk("retire_cnt", retire_cnt, m_rc);
        chk("INSTR", INSTR, m_instr);
    end

    // Stimulus: instruction memory with configurable latency, reactive pc_incr, random controls.
    logic [15:0] mem [256];
    logic [7:0]  inc_tab [8];
    logic [7:0]  paddr = 0;
    int          pend = 0, lat = 1;
    bit          directed = 1, noise = 0;

    function automatic int pick_lat();
        if (lat > 0) return lat;
        return ($urandom_range(9) == 0) ? int'($urandom_range(17, 14)) : int'($urandom_range(6, 1));
    endfunction

    task automatic step();
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin imem_rvalid = 1'b1; imem_rdata = mem[paddr]; end
        end else if (noise && $urandom_range(7) == 0) imem_rvalid = 1'b1;
        if (imem_req) begin pend = pick_lat(); paddr = imem_addr; end
        pc_incr = directed ? inc_tab[retire_cnt[2:0]] : 8'($urandom);
        if (!directed) begin
            run       = $urandom_range(9) != 0;
            clr_fault = $urandom_range(3) == 0;
        end
    endtask

    int acc, n, k;
    logic [3:0] op;

    initial begin
        foreach (mem[i]) mem[i] = 16'h1000;
        mem[0] = 16'h4012; mem[1] = 16'h3A55; mem[2] = 16'h8105; mem[5] = 16'h7000;
        inc_tab = '{8'h01, 8'h01, 8'hFD, 8'h01, 8'h05, 8'h02, 8'h03, 8'h01};
        repeat (3) step();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_outs", {phase, busy, fault, fault_code, imem_req}, 0);
        resetn = 1'b1;

        run = 1'b1; acc = 0; n = 0;
        for (int i = 0; i < 20 && retire_cnt == 0; i++) begin
            step();
            if (retire_cnt == 0) begin acc = acc * 4 + phase; n++; end
        end
        chk("seq1_len", n, 5);
        chk("seq1_phases", acc, 27);
        chk("pc_after_4012", pc, 8'h01);
        chk("req_addr1", {imem_req, imem_addr}, 9'h101);

        acc = 0; n = 1;
        for (int i = 0; i < 20 && retire_cnt == 1; i++) begin
            step();
            if (retire_cnt == 1) begin acc = acc * 4 + phase; n++; end
        end
        chk("seq2_len", n, 3);
        chk("seq2_phases", acc, 1);
        chk("pc_after_3A55", {phase, pc}, 10'h002);

        for (int i = 0; i < 20 && retire_cnt != 3; i++) step();
        chk("pc_FD_step", pc, 8'hFF);
        for (int i = 0; i < 20 && retire_cnt != 4; i++) step();
        chk("pc_wrap", pc, 8'h00);
        for (int i = 0; i < 20 && retire_cnt != 5; i++) step();
        chk("pc_plus5", pc, 8'h05);

        for (int i = 0; i < 20 && !fault; i++) step();
        run = 1'b0;
        chk("illegal_fault", {fault, fault_code, busy}, 4'b1010);
        chk("illegal_pc_held", pc, 8'h05);
        chk("illegal_instr", INSTR, 16'h7000);
        clr_fault = 1'b1; step(); clr_fault = 1'b0;
        chk("clr_state", {fault, fault_code, busy}, 0);
        chk("clr_pc", pc, RESET_PC);
        chk("clr_instr_held", INSTR, 16'h7000);

        mem[5] = 16'h5000;
        lat = 16; run = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        run = 1'b0;
        step();
        k = 0;
        for (int i = 0; i < 40 && !fault; i++) begin step(); k++; end
        chk("timeout_cycles", k, 15);
        chk("timeout_code", fault_code, 2);
        clr_fault = 1'b1; step(); clr_fault = 1'b0;

        lat = 15; run = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        run = 1'b0;
        for (int i = 0; i < 40 && retire_cnt == 5 && !fault; i++) step();
        chk("late_valid_nofault", {fault, retire_cnt}, 17'h00006);
        chk("late_valid_pc", pc, 8'h02);

        lat = 2; run = 1'b1;
        for (int i = 0; i < 20 && phase != 2; i++) step();
        run = 1'b0;
        for (int i = 0; i < 20 && retire_cnt != 7; i++) step();
        chk("rundrop_pc", pc, 8'h05);
        chk("rundrop_idle", {busy, phase}, 0);
        step();
        chk("rundrop_noreq", imem_req, 0);

        run = 1'b1;
        for (int i = 0; i < 20 && phase != 2; i++) step();
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_pc_cnt", {pc, retire_cnt}, {RESET_PC, 16'h0000});
        chk("async_rst_outs", {phase, busy, fault, fault_code, imem_req}, 0);
        chk("async_rst_instr", INSTR, 0);
        pend = 0; run = 1'b0;
        step(); step();
        resetn = 1'b1;

        foreach (mem[i]) begin
            op = 4'($urandom);
            if (!legal_mask[op] && $urandom_range(3) != 0) op = 4'($urandom_range(5));
            mem[i] = {op, 12'($urandom)};
        end
        directed = 0; noise = 1; lat = 0;
        repeat (3000) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simple_seq_ctrl.md
Name: simple_seq_ctrl

Overview:
- Instruction sequencer for the simple ISA core.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a request/valid handshake.
- Latches the fetched word onto INSTR and drives the phase input of the decode/execute block: IF=0, ID=1, EX=2, WB=3.
- At retirement, updates PC by the pc_incr that decode/execute returns. Illegal opcodes and fetch timeouts go to a sticky fault state instead of stopping simulation.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset and on fault clear.
- FETCH_TIMEOUT, 15, maximum number of cycles to wait for imem_rvalid after a request (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- clr_fault  in  1  one-cycle pulse; leaves FAULT. Ignored in every other state.
- imem_req  out  1  one-cycle fetch request.
- imem_addr  out  8  fetch address; equals pc.
- imem_rdata  in  16  fetched instruction word; sampled when imem_rvalid=1.
- imem_rvalid  in  1  read data valid; earliest one cycle after imem_req.
- pc_incr  in  8  two's-complement PC step from decode/execute, sampled in the retiring cycle.
- INSTR  out  16  current instruction to decode/execute.
- phase  out  2  current phase to decode/execute.
- pc  out  8  current program counter.
- busy  out  1  1 in every state except IDLE and FAULT.
- fault  out  1  1 while in FAULT.
- fault_code  out  2  0 = none, 1 = illegal opcode, 2 = fetch timeout.
- retire_cnt  out  16  count of retired instructions; wraps at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: state IDLE, pc=RESET_PC, INSTR=0, phase=0, imem_req=0, busy=0, fault=0, fault_code=0, retire_cnt=0, timeout counter=0.
- Reset asserted mid-instruction aborts the instruction immediately. No PC update and no retire.
- States and their phase output:
  - IDLE: phase=0.
  - FETCH_REQ: phase=0, imem_req=1.
  - FETCH_WAIT: phase=0.
  - ID: phase=1.
  - EX: phase=2.
  - WB: phase=3.
  - FAULT: phase=0.
  - phase is a registered output and changes only on a clock edge.
- Transitions:
  - IDLE -> FETCH_REQ when run=1.
  - FETCH_REQ -> FETCH_WAIT unconditionally. The timeout counter clears to 0.
  - FETCH_WAIT, imem_rvalid=1 with a legal opcode: INSTR<=imem_rdata, go to ID.
  - FETCH_WAIT, imem_rvalid=1 with an illegal opcode: INSTR<=imem_rdata, fault_code<=1, go to FAULT.
  - FETCH_WAIT, imem_rvalid=0: counter increments. When the counter reaches FETCH_TIMEOUT-1 with no valid data, fault_code<=2 and go to FAULT.
  - ID -> retire if opcode==3 (single-phase instruction); otherwise ID -> EX.
  - EX -> WB unconditionally.
  - WB -> retire.
  - Retire cycle (last cycle of ID for opcode 3, otherwise WB): pc<=pc+pc_incr modulo 256 and retire_cnt<=retire_cnt+1. Next state is FETCH_REQ if run=1, else IDLE.
  - FAULT -> IDLE on clr_fault=1. pc<=RESET_PC, fault_code<=0, and INSTR is held.
- Legal opcodes (INSTR[15:12]): 0, 1, 2, 3, 4, 5, 8, 9. All other values are illegal.
- imem_rvalid in any state other than FETCH_WAIT is ignored. rvalid arriving on the timeout cycle wins: data is accepted, no fault.
- run deasserted mid-instruction has no effect until the retire cycle.
- INSTR is stable from ID through retire.
- pc_incr is sampled only in the retire cycle, so decode/execute must drive it valid in ID (opcode 3) or WB.
- pc wrap: 8'hFF + 1 = 8'h00; 8'h00 + 8'hFE = 8'hFE.

Decomposition:
- Shared package simple_isa_pkg contains:
  - opcode enum: MOV_LD=0, MOV_ST=1, MOV_IND=2, MOV_IMM=3, ADD=4, SUB=5, JZ=8, JNZ=9;
  - phase constants IF, ID, EX, WB;
  - fault_code enum;
  - function is_legal_opcode(logic [3:0]);
  - function is_single_phase(logic [3:0]).
- The decode/execute block imports the same package so phase encodings cannot diverge.
- The state enum stays local to this module.
- No sub-module; a single always_ff state machine plus next-state always_comb.

Test Plan:
- Reset, run=1, memory with rvalid 1 cycle after req returning 16'h4012 at addr 0, pc_incr=1 -> phase sequence 0,0,1,2,3; pc=1 and retire_cnt=1 after WB; next imem_req at addr 1.
- Fetch 16'h3A55 (opcode 3) -> phase 0,0,1 then back to 0; retire on ID; pc+1.
- Fetch 16'h8105, pc_incr=8'hFD at pc=8'h02 -> pc=8'hFF; then pc_incr=1 -> pc wraps to 8'h00.
- Fetch 16'h7000 -> fault=1, fault_code=1, busy=0, pc unchanged; clr_fault pulse -> IDLE, pc=RESET_PC, fault=0.
- No rvalid after req with FETCH_TIMEOUT=15 -> FAULT with fault_code=2 exactly 15 cycles after FETCH_WAIT entry; rvalid on cycle 15 of waiting -> no fault.
- run dropped during EX -> instruction completes through WB, pc updates, then IDLE with busy=0. resetn asserted during EX -> all outputs return to reset values asynchronously.
